// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: sequencer states and the sizing helpers
// used by the serial arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-position counter width for a WIDTH-bit serial operation.
    // Clamped to 1 so a degenerate width still yields a legal vector.
    function automatic int counter_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    localparam int DEFAULT_CNT_W = counter_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_8bit_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;

    modport master (
        output start, in1, in2, b_in,
        input  busy, done, diff, b_out, ovf
    );

    modport slave (
        input  start, in1, in2, b_in,
        output busy, done, diff, b_out, ovf
    );
endinterface

// File: rtl/serial_subtractor_8bit_fa.sv
// Single-bit full adder used as the serial arithmetic slice.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial two's-complement subtractor: diff = in1 - in2 - b_in, computed
// LSB first as in1 + ~in2 + ~b_in through one full-adder slice over WIDTH
// cycles. Reports unsigned borrow-out and signed overflow. WIDTH must be >= 2.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; last result held on the outputs
//   ST_RUN  | one bit per clock through the slice, busy high
//   ST_DONE | result registered this cycle, done high for one cycle
module serial_subtractor_8bit
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_subtractor_8bit_if.slave bus
);

    localparam int CW = counter_width(WIDTH);
    // The result shift register only needs WIDTH-1 bits: the MSB comes
    // straight from the slice on the final edge.
    localparam int RW = WIDTH - 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MSB_M1 = CW'(WIDTH - 2);

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] opa_q,     opa_d;
    logic [WIDTH-1:0] opb_q,     opb_d;
    logic             carry_q,   carry_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [RW-1:0]    res_q,     res_d;
    logic             msb_cin_q, msb_cin_d;
    logic [WIDTH-1:0] diff_q,    diff_d;
    logic             b_out_q,   b_out_d;
    logic             ovf_q,     ovf_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic fa_sum;
    logic fa_cout;

    FullAdder u_slice (
        .a     (opa_q[0]),
        .b     (opb_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    // Next-state, datapath shift and result capture.
    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        carry_d   = carry_q;
        count_d   = count_q;
        res_d     = res_q;
        msb_cin_d = msb_cin_q;
        diff_d    = diff_q;
        b_out_d   = b_out_q;
        ovf_d     = ovf_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    opa_d   = bus.in1;
                    opb_d   = ~bus.in2;
                    carry_d = ~bus.b_in;
                    count_d = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = fa_cout;
                count_d = count_q + CW'(1);
                res_d   = RW'({fa_sum, res_q} >> 1);
                // Carry out of bit WIDTH-2 is the carry into the MSB.
                if (count_q == CNT_MSB_M1) begin
                    msb_cin_d = fa_cout;
                end
                if (count_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    diff_d  = {fa_sum, res_q};
                    b_out_d = ~fa_cout;
                    ovf_d   = msb_cin_q ^ fa_cout;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            carry_q   <= 1'b0;
            count_q   <= '0;
            res_q     <= '0;
            msb_cin_q <= 1'b0;
            diff_q    <= '0;
            b_out_q   <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            carry_q   <= carry_d;
            count_q   <= count_d;
            res_q     <= res_d;
            msb_cin_q <= msb_cin_d;
            diff_q    <= diff_d;
            b_out_q   <= b_out_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.diff  = diff_q;
    assign bus.b_out = b_out_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Bench for the serial subtractor: directed vector table, randomized
// operations against an arithmetic reference, handshake and reset sequences.
module tb_serial_subtractor_8bit;

    localparam int W = 8;

    logic clk;
    logic rst_n;

    serial_subtractor_8bit_if #(.WIDTH(W)) bus_if ();

    serial_subtractor_8bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bi,
                           output logic [7:0] d, output logic bo, output logic ov);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (a >= 8'h80) ? ua - 256 : ua;
        sb = (b >= 8'h80) ? ub - 256 : ub;
        ur = ua - ub - int'(bi);
        sr = sa - sb - int'(bi);
        d  = 8'(ur & 255);
        bo = (ua < ub + int'(bi));
        ov = (sr > 127) || (sr < -128);
    endtask

    // Launch one operation and wait for done; reports latency and busy cycles.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         output logic [7:0] d, output logic bo, output logic ov,
                         output int lat, output int busy_cnt, output bit overlap);
        @(negedge clk);
        bus_if.in1   = a;
        bus_if.in2   = b;
        bus_if.b_in  = bi;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        overlap  = 1'b0;
        if (bus_if.busy) busy_cnt++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.busy && bus_if.done) overlap = 1'b1;
            if (bus_if.done) begin
                lat = k;
                break;
            end
            if (bus_if.busy) busy_cnt++;
        end
        d  = bus_if.diff;
        bo = bus_if.b_out;
        ov = bus_if.ovf;
    endtask

    logic [7:0] d, ed;
    logic       bo, ov, ebo, eov;
    int         lat, bcnt, lat2;
    bit         ovl, seen;
    logic [7:0] ra, rb;
    logic       rbi;

    initial begin
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.in1   = '0;
        bus_if.in2   = '0;
        bus_if.b_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus_if.busy), 32'h0);
        chk("rst_done", 32'(bus_if.done), 32'h0);
        chk("rst_diff", 32'(bus_if.diff), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bi, d, bo, ov, lat, bcnt, ovl);
            chk($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].d));
            chk($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].bo));
            chk($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
            if (i == 0) begin
                chk("vec0_busy_cycles", 32'(bcnt), 32'(W));
                chk("vec0_busy_done_overlap", 32'(ovl), 32'h0);
                @(posedge clk);
                #1;
                chk("vec0_done_one_cycle", 32'(bus_if.done), 32'h0);
                chk("vec0_result_held", 32'(bus_if.diff), 32'h02);
            end
        end

        // Randomized against the reference
        for (int i = 0; i < 30; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rbi = 1'($urandom_range(1));
            ref_sub(ra, rb, rbi, ed, ebo, eov);
            do_op(ra, rb, rbi, d, bo, ov, lat, bcnt, ovl);
            chk($sformatf("rnd%0d_diff a=%0h b=%0h bi=%0d", i, ra, rb, rbi), 32'(d), 32'(ed));
            chk($sformatf("rnd%0d_bout", i), 32'(bo), 32'(ebo));
            chk($sformatf("rnd%0d_ovf", i), 32'(ov), 32'(eov));
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(W));
        end

        // start during RUN is ignored
        @(negedge clk);
        bus_if.in1 = 8'h10; bus_if.in2 = 8'h01; bus_if.b_in = 1'b0; bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus_if.in1 = 8'hAA; bus_if.in2 = 8'h55; bus_if.b_in = 1'b1; bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        lat = -1;
        for (int k = 4; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.done) begin
                lat = k;
                break;
            end
        end
        chk("ignore_start_latency", 32'(lat), 32'(W));
        chk("ignore_start_diff", 32'(bus_if.diff), 32'h0F);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.busy || bus_if.done) seen = 1'b1;
        end
        chk("ignore_start_no_second_op", 32'(seen), 32'h0);

        // Back-to-back: start held through the done cycle
        @(negedge clk);
        bus_if.in1 = 8'h80; bus_if.in2 = 8'h01; bus_if.b_in = 1'b0; bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in1 = 8'h00; bus_if.in2 = 8'h01; bus_if.b_in = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.done) begin
                lat = k;
                break;
            end
        end
        chk("b2b_first_latency", 32'(lat), 32'(W));
        chk("b2b_first_diff", 32'(bus_if.diff), 32'h7F);
        chk("b2b_first_ovf", 32'(bus_if.ovf), 32'h1);
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        chk("b2b_accept_busy", 32'(bus_if.busy), 32'h1);
        chk("b2b_accept_done_low", 32'(bus_if.done), 32'h0);
        lat2 = -1;
        for (int k = lat + 2; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.done) begin
                lat2 = k;
                break;
            end
        end
        chk("b2b_second_spacing", 32'(lat2 - lat), 32'(W + 1));
        chk("b2b_second_diff", 32'(bus_if.diff), 32'hFF);
        chk("b2b_second_bout", 32'(bus_if.b_out), 32'h1);

        // Reset mid-RUN
        @(negedge clk);
        bus_if.in1 = 8'h05; bus_if.in2 = 8'h03; bus_if.b_in = 1'b0; bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus_if.busy), 32'h0);
        chk("midrst_done", 32'(bus_if.done), 32'h0);
        chk("midrst_diff", 32'(bus_if.diff), 32'h0);
        chk("midrst_bout", 32'(bus_if.b_out), 32'h0);
        chk("midrst_ovf", 32'(bus_if.ovf), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.done || bus_if.busy) seen = 1'b1;
        end
        chk("midrst_no_done", 32'(seen), 32'h0);
        do_op(8'h05, 8'h03, 1'b0, d, bo, ov, lat, bcnt, ovl);
        chk("post_rst_diff", 32'(d), 32'h02);
        chk("post_rst_latency", 32'(lat), 32'(W));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
